// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet stats scheduling slice.
// Holds the stat and action index encodings, the per-action command table
// (stat, signed delta, whether a second command follows), the scheduler FSM
// state encoding and small index helpers used by the scheduler and arbiter.
package tamagotchi_pkg;

    localparam int NUM_STATS   = 6;
    localparam int NUM_ACTIONS = 6;

    // Stat indices as seen on cmd_stat.
    localparam logic [2:0] STAT_HUNGER    = 3'd0;
    localparam logic [2:0] STAT_HAPPINESS = 3'd1;
    localparam logic [2:0] STAT_HEALTH    = 3'd2;
    localparam logic [2:0] STAT_HYGIENE   = 3'd3;
    localparam logic [2:0] STAT_ENERGY    = 3'd4;
    localparam logic [2:0] STAT_SOCIAL    = 3'd5;

    // Action indices, matching the act_req / grant bit positions.
    localparam logic [2:0] ACT_FEED  = 3'd0;
    localparam logic [2:0] ACT_PLAY  = 3'd1;
    localparam logic [2:0] ACT_CLEAN = 3'd2;
    localparam logic [2:0] ACT_SLEEP = 3'd3;
    localparam logic [2:0] ACT_HEAL  = 3'd4;
    localparam logic [2:0] ACT_CHAT  = 3'd5;

    // Decay always subtracts one (two's complement 4-bit).
    localparam logic [3:0] DECAY_DELTA = 4'hF;
    // Skip value that never matches a stat index, i.e. "skip nothing".
    localparam logic [2:0] NO_SKIP     = 3'd7;

    typedef struct packed {
        logic [2:0] stat;
        logic [3:0] delta;
    } stat_cmd_t;

    typedef struct packed {
        stat_cmd_t first;
        stat_cmd_t second;
        logic      has_second;
    } action_entry_t;

    // Deltas are 4-bit two's complement: 4'hF = -1, 4'hE = -2.
    localparam action_entry_t FEED_ENTRY = '{
        first:  '{stat: STAT_HUNGER,    delta: 4'h4},
        second: '{stat: STAT_HYGIENE,   delta: 4'hF},
        has_second: 1'b1};
    localparam action_entry_t PLAY_ENTRY = '{
        first:  '{stat: STAT_HAPPINESS, delta: 4'h3},
        second: '{stat: STAT_ENERGY,    delta: 4'hE},
        has_second: 1'b1};
    localparam action_entry_t CLEAN_ENTRY = '{
        first:  '{stat: STAT_HYGIENE,   delta: 4'h4},
        second: '{stat: STAT_HUNGER,    delta: 4'h0},
        has_second: 1'b0};
    localparam action_entry_t SLEEP_ENTRY = '{
        first:  '{stat: STAT_ENERGY,    delta: 4'h5},
        second: '{stat: STAT_SOCIAL,    delta: 4'hF},
        has_second: 1'b1};
    localparam action_entry_t HEAL_ENTRY = '{
        first:  '{stat: STAT_HEALTH,    delta: 4'h3},
        second: '{stat: STAT_HAPPINESS, delta: 4'hF},
        has_second: 1'b1};
    localparam action_entry_t CHAT_ENTRY = '{
        first:  '{stat: STAT_SOCIAL,    delta: 4'h3},
        second: '{stat: STAT_ENERGY,    delta: 4'hF},
        has_second: 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD_A = 2'd1,
        ST_CMD_B = 2'd2,
        ST_DECAY = 2'd3
    } sched_state_e;

    function automatic action_entry_t action_lookup(input logic [2:0] act);
        action_entry_t e;
        case (act)
            ACT_FEED:  e = FEED_ENTRY;
            ACT_PLAY:  e = PLAY_ENTRY;
            ACT_CLEAN: e = CLEAN_ENTRY;
            ACT_SLEEP: e = SLEEP_ENTRY;
            ACT_HEAL:  e = HEAL_ENTRY;
            ACT_CHAT:  e = CHAT_ENTRY;
            default:   e = '0;
        endcase
        return e;
    endfunction

    // (a + b) mod 6 for operands already in 0..5.
    function automatic logic [2:0] wrap6_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd6) begin
            s = s - 4'd6;
        end else begin
            s = s;
        end
        return s[2:0];
    endfunction

    function automatic logic [2:0] onehot6_to_idx(input logic [5:0] oh);
        logic [2:0] idx;
        case (oh)
            6'b000001: idx = 3'd0;
            6'b000010: idx = 3'd1;
            6'b000100: idx = 3'd2;
            6'b001000: idx = 3'd3;
            6'b010000: idx = 3'd4;
            6'b100000: idx = 3'd5;
            default:   idx = 3'd0;
        endcase
        return idx;
    endfunction

    // First stat index of a decay sweep, stepping over the skipped one.
    function automatic logic [2:0] first_decay_idx(input logic [2:0] skip);
        logic [2:0] idx;
        if (skip == 3'd0) begin
            idx = 3'd1;
        end else begin
            idx = 3'd0;
        end
        return idx;
    endfunction

    // Next stat index of a decay sweep; a result >= 6 means the sweep is done.
    function automatic logic [2:0] next_decay_idx(input logic [2:0] idx, input logic [2:0] skip);
        logic [2:0] n;
        n = idx + 3'd1;
        if (n == skip) begin
            n = n + 3'd1;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/stats_action_scheduler_rr_arbiter6.sv
// rr_arbiter6: combinational six-way round-robin arbiter.
// Picks the lowest pending index at or after ptr (wrapping past 5 to 0).
// Ports:
//   pending  [5:0] in   outstanding requests
//   ptr      [2:0] in   search start, 0..5
//   grant    [5:0] out  one-hot winner, zero when nothing is pending
//   next_ptr [2:0] out  winner + 1 mod 6, or ptr when nothing is pending
module rr_arbiter6
    import tamagotchi_pkg::*;
(
    input  logic [5:0] pending,
    input  logic [2:0] ptr,
    output logic [5:0] grant,
    output logic [2:0] next_ptr
);

    logic       found_s;
    logic [2:0] cand_s;

    // Scan the six positions starting at ptr and keep the first pending one.
    always_comb begin
        grant    = 6'd0;
        next_ptr = ptr;
        found_s  = 1'b0;
        cand_s   = 3'd0;
        for (int k = 0; k < NUM_ACTIONS; k++) begin
            cand_s = wrap6_add(ptr, 3'(k));
            if (!found_s && pending[cand_s]) begin
                found_s        = 1'b1;
                grant[cand_s]  = 1'b1;
                next_ptr       = wrap6_add(cand_s, 3'd1);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/stats_action_scheduler.sv
// stats_action_scheduler: sequences every write into the pet stats datapath.
// Six action buttons are edge-captured into pending requests and granted
// round-robin; a free-running decay timer periodically requests a sweep that
// subtracts one from every stat. Each granted job is expanded into signed
// delta commands on a valid/ready port. Decay beats actions at arbitration,
// and nothing preempts a job already running.
// Optional build macro DECAY_JITTER_EN: when defined, rand_in[2:0] sampled on
// entry to a decay sweep names a stat (if < 6) that the sweep skips.
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   act_req   [5:0] level action buttons (feed, play, clean, sleep, heal, chat)
//   rand_in   [3:0] LFSR value (used only with DECAY_JITTER_EN)
//   cmd_ready       datapath accepts the command this cycle
//   cmd_valid       command present; cmd_stat / cmd_delta stable until accepted
//   cmd_stat  [2:0] stat index
//   cmd_delta [3:0] signed delta
//   grant     [5:0] one-cycle one-hot pulse per granted action
//   decay_tick      one-cycle pulse on decay timer wrap
//   busy            scheduler is running a job
module stats_action_scheduler
    import tamagotchi_pkg::*;
#(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] act_req,
    input  logic [3:0] rand_in,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_stat,
    output logic [3:0] cmd_delta,
    output logic [5:0] grant,
    output logic       decay_tick,
    output logic       busy
);

    sched_state_e  state_r;
    logic [5:0]    act_prev_r;
    logic [5:0]    pending_r;
    logic          decay_pend_r;
    logic [23:0]   count_r;
    logic [2:0]    ptr_r;
    logic [2:0]    cur_act_r;
    logic [2:0]    idx_r;

    logic [5:0]    edge_s;
    logic          wrap_s;
    logic          take_decay_s;
    logic          take_action_s;
    logic [5:0]    grant_clear_s;
    logic          decay_pend_next_s;
    logic [5:0]    arb_grant_s;
    logic [2:0]    arb_next_ptr_s;
    action_entry_t entry_s;
    logic [2:0]    skip_entry_s;
    logic [2:0]    skip_cur_s;
    logic [2:0]    nxt_idx_s;
    logic          unused_rand_s;

`ifdef DECAY_JITTER_EN
    logic [2:0] skip_r;

    assign skip_entry_s  = rand_in[2:0];
    assign skip_cur_s    = skip_r;
    assign unused_rand_s = rand_in[3];

    // Latch the jitter skip index when a decay sweep starts.
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_r <= NO_SKIP;
        end else if (take_decay_s) begin
            skip_r <= rand_in[2:0];
        end else begin
            skip_r <= skip_r;
        end
    end
`else
    assign skip_entry_s  = NO_SKIP;
    assign skip_cur_s    = NO_SKIP;
    assign unused_rand_s = ^rand_in;
`endif

    rr_arbiter6 u_arb (
        .pending  (pending_r),
        .ptr      (ptr_r),
        .grant    (arb_grant_s),
        .next_ptr (arb_next_ptr_s)
    );

    assign edge_s        = act_req & ~act_prev_r;
    assign wrap_s        = (count_r == (MAX_COUNT - 24'd1));
    assign take_decay_s  = (state_r == ST_IDLE) && decay_pend_r;
    assign take_action_s = (state_r == ST_IDLE) && !decay_pend_r && (pending_r != 6'd0);
    assign grant_clear_s = take_action_s ? arb_grant_s : 6'd0;
    assign entry_s       = action_lookup(cur_act_r);
    assign nxt_idx_s     = next_decay_idx(idx_r, skip_cur_s);

    // A wrap only arms the decay request when none is outstanding; a wrap that
    // lands while one is already pending is dropped, even on the take cycle.
    always_comb begin
        decay_pend_next_s = decay_pend_r;
        if (wrap_s && !decay_pend_r) begin
            decay_pend_next_s = 1'b1;
        end else if (take_decay_s) begin
            decay_pend_next_s = 1'b0;
        end else begin
            decay_pend_next_s = decay_pend_r;
        end
    end

    // Decay timer, button edge capture and pending request bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_prev_r   <= 6'b111111;
            pending_r    <= 6'd0;
            decay_pend_r <= 1'b0;
            count_r      <= 24'd0;
            decay_tick   <= 1'b0;
            grant        <= 6'd0;
        end else begin
            act_prev_r   <= act_req;
            // A new edge in the grant cycle re-arms the request.
            pending_r    <= (pending_r & ~grant_clear_s) | edge_s;
            decay_pend_r <= decay_pend_next_s;
            count_r      <= wrap_s ? 24'd0 : (count_r + 24'd1);
            decay_tick   <= wrap_s;
            grant        <= grant_clear_s;
        end
    end

    // Scheduler FSM: each job spends one cycle after entry before raising
    // cmd_valid, then advances one command per handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= 3'd0;
            cur_act_r <= 3'd0;
            idx_r     <= 3'd0;
            cmd_valid <= 1'b0;
            cmd_stat  <= 3'd0;
            cmd_delta <= 4'd0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cmd_valid <= 1'b0;
                    if (decay_pend_r) begin
                        state_r <= ST_DECAY;
                        busy    <= 1'b1;
                        idx_r   <= first_decay_idx(skip_entry_s);
                    end else if (pending_r != 6'd0) begin
                        state_r   <= ST_CMD_A;
                        busy      <= 1'b1;
                        ptr_r     <= arb_next_ptr_s;
                        cur_act_r <= onehot6_to_idx(arb_grant_s);
                    end else begin
                        busy <= 1'b0;
                    end
                end

                ST_CMD_A: begin
                    if (!cmd_valid) begin
                        cmd_valid <= 1'b1;
                        cmd_stat  <= entry_s.first.stat;
                        cmd_delta <= entry_s.first.delta;
                    end else if (cmd_ready) begin
                        if (entry_s.has_second) begin
                            state_r   <= ST_CMD_B;
                            cmd_stat  <= entry_s.second.stat;
                            cmd_delta <= entry_s.second.delta;
                        end else begin
                            state_r   <= ST_IDLE;
                            busy      <= 1'b0;
                            cmd_valid <= 1'b0;
                            cmd_stat  <= 3'd0;
                            cmd_delta <= 4'd0;
                        end
                    end else begin
                        cmd_valid <= cmd_valid;
                    end
                end

                ST_CMD_B: begin
                    if (cmd_ready) begin
                        state_r   <= ST_IDLE;
                        busy      <= 1'b0;
                        cmd_valid <= 1'b0;
                        cmd_stat  <= 3'd0;
                        cmd_delta <= 4'd0;
                    end else begin
                        cmd_valid <= cmd_valid;
                    end
                end

                ST_DECAY: begin
                    if (!cmd_valid) begin
                        cmd_valid <= 1'b1;
                        cmd_stat  <= idx_r;
                        cmd_delta <= DECAY_DELTA;
                    end else if (cmd_ready) begin
                        if (nxt_idx_s >= 3'(NUM_STATS)) begin
                            state_r   <= ST_IDLE;
                            busy      <= 1'b0;
                            cmd_valid <= 1'b0;
                            cmd_stat  <= 3'd0;
                            cmd_delta <= 4'd0;
                        end else begin
                            idx_r    <= nxt_idx_s;
                            cmd_stat <= nxt_idx_s;
                        end
                    end else begin
                        cmd_valid <= cmd_valid;
                    end
                end

                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stats_action_scheduler.sv
// Self-checking bench for stats_action_scheduler (MAX_COUNT = 16).
// A transaction-level reference model predicts grants, decay ticks, busy and
// the command stream; predicted commands go into a scoreboard queue that a
// separate monitor drains on every DUT handshake.
module tb_stats_action_scheduler;

    localparam logic [23:0] MAXC = 24'd16;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] act_req;
    logic [3:0] rand_in;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_stat;
    logic [3:0] cmd_delta;
    logic [5:0] grant;
    logic       decay_tick;
    logic       busy;

    always #5 clk = ~clk;

    stats_action_scheduler #(.MAX_COUNT(MAXC)) dut (
        .clk        (clk),
        .reset      (reset),
        .act_req    (act_req),
        .rand_in    (rand_in),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_stat   (cmd_stat),
        .cmd_delta  (cmd_delta),
        .grant      (grant),
        .decay_tick (decay_tick),
        .busy       (busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] stat;
        logic [3:0] delta;
    } cmd_t;

    cmd_t sb[$];

    // Action table: first (stat, delta) and optional second (stat < 0 = none).
    int a1_stat[6] = '{0, 1, 3, 4, 2, 5};
    int a1_dlt[6]  = '{4, 3, 4, 5, 3, 3};
    int a2_stat[6] = '{3, 4, -1, 5, 1, 4};
    int a2_dlt[6]  = '{-1, -2, 0, -1, -1, -1};

    // Reference model state, describing the cycle currently on the outputs.
    bit         m_init = 1'b0;
    logic [5:0] m_prev, m_pend, m_grant;
    bit         m_dpend, m_busy, m_gap, m_tick, m_in_decay;
    int         m_cnt, m_ptr, m_left;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev     = 6'h3F;
        m_pend     = 6'h00;
        m_grant    = 6'h00;
        m_dpend    = 1'b0;
        m_busy     = 1'b0;
        m_gap      = 1'b0;
        m_tick     = 1'b0;
        m_in_decay = 1'b0;
        m_cnt      = 0;
        m_ptr      = 0;
        m_left     = 0;
        sb.delete();
    endtask

    // Advance the model by one clock using the inputs present this cycle.
    task automatic model_step();
        logic [5:0] rise;
        bit         d_old, took_decay, skip;
        int         g;
        rise       = act_req & ~m_prev;
        d_old      = m_dpend;
        took_decay = 1'b0;
        m_grant    = 6'h00;
        m_tick     = (m_cnt == int'(MAXC) - 1);
        if (m_busy) begin
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (cmd_ready) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy     = 1'b0;
                    m_in_decay = 1'b0;
                end
            end
        end else if (d_old) begin
            took_decay = 1'b1;
            m_left     = 0;
            for (int s = 0; s < 6; s++) begin
                skip = 1'b0;
`ifdef DECAY_JITTER_EN
                skip = (int'(rand_in[2:0]) == s);
`endif
                if (!skip) begin
                    sb.push_back('{stat: 3'(s), delta: 4'hF});
                    m_left++;
                end
            end
            m_busy = 1'b1; m_gap = 1'b1; m_in_decay = 1'b1;
        end else if (m_pend != 6'h00) begin
            g = -1;
            for (int k = 0; k < 6; k++) begin
                if (g < 0 && m_pend[(m_ptr + k) % 6]) g = (m_ptr + k) % 6;
            end
            m_grant[g] = 1'b1;
            m_pend[g]  = 1'b0;
            m_ptr      = (g + 1) % 6;
            sb.push_back('{stat: 3'(a1_stat[g]), delta: 4'(a1_dlt[g])});
            m_left = 1;
            if (a2_stat[g] >= 0) begin
                sb.push_back('{stat: 3'(a2_stat[g]), delta: 4'(a2_dlt[g])});
                m_left = 2;
            end
            m_busy = 1'b1; m_gap = 1'b1;
        end
        m_pend = m_pend | rise;
        m_prev = act_req;
        if (m_tick && !d_old) m_dpend = 1'b1;
        else if (took_decay)  m_dpend = 1'b0;
        m_cnt = m_tick ? 0 : m_cnt + 1;
    endtask

    // Model process: compare per-cycle outputs, then advance.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (m_init) begin
                check_eq("cmd_valid", cmd_valid, m_busy && !m_gap);
                check_eq("busy", busy, m_busy);
                check_eq("grant", grant, m_grant);
                check_eq("decay_tick", decay_tick, m_tick);
            end
            if (reset === 1'b1) begin
                model_reset();
                m_init = 1'b1;
            end else if (m_init) begin
                model_step();
            end
        end
    end

    // Monitor: compare the presented command with the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (m_init && cmd_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL cmd_unexpected actual=stat%0d/delta%0h expected=none at %0t",
                             cmd_stat, cmd_delta, $time);
                end else begin
                    check_eq("cmd_stat", cmd_stat, sb[0].stat);
                    check_eq("cmd_delta", cmd_delta, sb[0].delta);
                    if (cmd_ready === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stimulus.
    initial begin
        bit hit;
        reset = 1'b1; act_req = 6'b000001; cmd_ready = 1'b1; rand_in = 4'd0;
        step(3);
        reset = 1'b0;
        step(5);                       // button held through reset: no grant
        act_req = 6'b000000; step(1);
        act_req = 6'b000001; step(2);  // feed
        act_req = 6'b000000; step(8);
        act_req = 6'b010010; step(1);  // play + heal together
        act_req = 6'b000000; step(14);
        step(24);                      // idle: decay sweep
        act_req = 6'b000001; step(1);  // feed with a 12-cycle stall
        act_req = 6'b000000; cmd_ready = 1'b0; step(12);
        cmd_ready = 1'b1; step(10);
        act_req = 6'b000100; step(1);  // clean with a stall spanning two wraps
        act_req = 6'b000000; cmd_ready = 1'b0; step(40);
        cmd_ready = 1'b1; step(20);

        // Reset while the decay sweep presents stat 3.
        rand_in = 4'd2;
        hit = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            step(1);
            if (m_in_decay && cmd_valid === 1'b1 && cmd_stat === 3'd3) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL decay_idx3_wait actual=timeout expected=stat3_in_decay");
        end
        reset = 1'b1; step(1);
        reset = 1'b0; step(40);        // next sweep runs with rand_in = 2

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(0, 3) == 0) act_req = 6'($urandom_range(0, 63));
            else if ($urandom_range(0, 1) == 0) act_req = 6'h00;
            cmd_ready = ($urandom_range(0, 9) < 7);
            rand_in   = 4'($urandom);
            reset     = ($urandom_range(0, 199) == 0);
            step(1);
        end
        reset = 1'b0; act_req = 6'h00; cmd_ready = 1'b1;
        step(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
